// File: rtl/pulpemu_gpio_boot_sequencer.sv
// pulpemu_gpio_boot_sequencer: sequences PULP SoC reset/clock/fetch over the GPIO bridge and services flush handshakes.
module pulpemu_gpio_boot_sequencer #(
  parameter int RST_CYCLES = 16,
  parameter int CLK_SETTLE = 8,
  parameter int BOOT_DELAY = 4,
  parameter int TIMEOUT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 mode_fmc_zynqn_i,
  input  logic                 fault_en_i,
  input  logic                 trace_active_i,
  input  logic [2:0]           safen_i,
  input  logic                 stdout_ack_i,
  input  logic                 trace_ack_i,
  input  logic [31:0]          pulp2zynq_gpio_i,
  output logic [31:0]          zynq2pulp_gpio_o,
  output logic                 stdout_wait_o,
  output logic                 trace_wait_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [1:0]           ret_val_o,
  output logic [2:0]           state_o
);
  localparam int PA   = RST_CYCLES > CLK_SETTLE ? RST_CYCLES : CLK_SETTLE;
  localparam int PMAX = PA > BOOT_DELAY ? PA : BOOT_DELAY;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int CW   = PW > TIMEOUT_W ? PW : TIMEOUT_W;
  localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_CLKON = 3'd2,
                         S_BOOT = 3'd3, S_RUN = 3'd4, S_DONE = 3'd5;
  logic [2:0] state, state_n;
  logic [CW-1:0] cnt;
  logic eoc, tmo_hit, in_flush, wait_en, fs_n, ft_n;
  logic [31:0] gpio_n;
  logic unused_status;
  assign unused_status = ^pulp2zynq_gpio_i[31:5];
  assign eoc      = pulp2zynq_gpio_i[0];
  assign tmo_hit  = |timeout_i && cnt == CW'(timeout_i) - CW'(1);
  assign in_flush = state == S_BOOT || state == S_RUN;
  assign wait_en  = !abort_i && (state_n == S_BOOT || state_n == S_RUN);
  // flushed bit drops as soon as the SoC stops asking; ack only counts while we were asking
  assign fs_n = pulp2zynq_gpio_i[3] & (zynq2pulp_gpio_o[3] | (stdout_wait_o & stdout_ack_i));
  assign ft_n = pulp2zynq_gpio_i[4] & (zynq2pulp_gpio_o[4] | (trace_wait_o & trace_ack_i));
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : (&cnt ? cnt : cnt + CW'(1));
    end
  end

  always_comb begin
    state_n = state;
    if (abort_i) state_n = S_IDLE;
    else
      case (state)
        S_IDLE:  state_n = start_i ? S_RST : S_IDLE;
        S_RST:   state_n = cnt == CW'(RST_CYCLES - 1) ? S_CLKON : S_RST;
        S_CLKON: state_n = cnt == CW'(CLK_SETTLE - 1) ? S_BOOT : S_CLKON;
        S_BOOT:  state_n = cnt == CW'(BOOT_DELAY - 1) ? S_RUN : S_BOOT;
        S_RUN:   state_n = eoc ? S_DONE : (tmo_hit ? S_IDLE : S_RUN);
        default: state_n = S_IDLE;
      endcase
  end

  always_comb begin
    gpio_n = zynq2pulp_gpio_o;
    if (abort_i) gpio_n = zynq2pulp_gpio_o & ~32'hC000_0019;
    else if (state == S_IDLE && start_i)
      gpio_n = {2'b00, fault_en_i, 20'b0, safen_i, trace_active_i, 2'b00, mode_fmc_zynqn_i, 2'b00};
    else begin
      if (in_flush) gpio_n[4:3] = {ft_n, fs_n};
      case (state_n)
        S_CLKON: gpio_n[30] = 1'b1;
        S_BOOT:  gpio_n[31:30] = 2'b11;
        S_RUN:   gpio_n[0] = 1'b1;
        S_DONE:  gpio_n[0] = 1'b0;
        S_IDLE:  if (state == S_RUN) {gpio_n[31:30], gpio_n[0]} = 3'b000;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zynq2pulp_gpio_o <= 32'h0000_01C0;
      stdout_wait_o    <= 1'b0;
      trace_wait_o     <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      timeout_o        <= 1'b0;
      ret_val_o        <= 2'b00;
    end else begin
      zynq2pulp_gpio_o <= gpio_n;
      stdout_wait_o    <= wait_en & pulp2zynq_gpio_i[3] & ~gpio_n[3];
      trace_wait_o     <= wait_en & pulp2zynq_gpio_i[4] & ~gpio_n[4];
      busy_o           <= state_n != S_IDLE;
      done_o           <= state_n == S_DONE;
      timeout_o        <= !abort_i && state == S_RUN && state_n == S_IDLE;
      ret_val_o        <= (!abort_i && state == S_RUN && eoc) ? pulp2zynq_gpio_i[2:1] : ret_val_o;
    end
  end
endmodule

// File: tb/tb_pulpemu_gpio_boot_sequencer.sv
// tb_pulpemu_gpio_boot_sequencer: directed checks of boot timing, flush handshake, EOC, timeout, abort and reset.
module tb_pulpemu_gpio_boot_sequencer;
  logic clk = 1'b0;
  logic rst, start, abort, mode, fault, trace_act, sack, tack;
  logic [31:0] tmo, pulp, gpio;
  logic [2:0] safen, state;
  logic swait, twait, busy, done, tout;
  logic [1:0] ret;
  int n_cmp = 0;
  int n_bad = 0;

  pulpemu_gpio_boot_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .timeout_i(tmo),
    .mode_fmc_zynqn_i(mode), .fault_en_i(fault), .trace_active_i(trace_act), .safen_i(safen),
    .stdout_ack_i(sack), .trace_ack_i(tack), .pulp2zynq_gpio_i(pulp),
    .zynq2pulp_gpio_o(gpio), .stdout_wait_o(swait), .trace_wait_o(twait), .busy_o(busy),
    .done_o(done), .timeout_o(tout), .ret_val_o(ret), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic cfg(logic m, logic f, logic t, logic [2:0] s);
    mode = m; fault = f; trace_act = t; safen = s;
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; sack = 0; tack = 0; tmo = 0; pulp = 0;
    cfg(1'b1, 1'b1, 1'b1, 3'b101);
    tick(3);
    chk("rst_gpio", gpio, 32'h0000_01C0);
    chk("rst_state", 32'(state), 0);
    chk("rst_flags", {busy, done, tout, swait, twait, ret}, 0);
    rst = 1'b0;
    tick(2);
    // boot sequence, config word 0x20000164
    launch;
    chk("rst_entry_state", 32'(state), 1);
    chk("rst_entry_busy", 32'(busy), 1);
    chk("rst_entry_gpio", gpio, 32'h2000_0164);
    tick(15);
    chk("rst_last_state", 32'(state), 1);
    chk("rst_last_gpio", gpio, 32'h2000_0164);
    tick(1);
    chk("clkon_state", 32'(state), 2);
    chk("clkon_gpio", gpio, 32'h6000_0164);
    tick(7);
    chk("clkon_last_gpio", gpio, 32'h6000_0164);
    tick(1);
    chk("boot_state", 32'(state), 3);
    chk("boot_gpio", gpio, 32'hE000_0164);
    tick(3);
    chk("boot_last_gpio", gpio, 32'hE000_0164);
    tick(1);
    chk("run_state", 32'(state), 4);
    chk("run_gpio", gpio, 32'hE000_0165);
    // stdout flush handshake
    pulp = 32'h8;
    tick(1);
    chk("sout_wait", 32'(swait), 1);
    sack = 1'b1;
    tick(1);
    sack = 1'b0;
    chk("sout_flushed_gpio", gpio, 32'hE000_016D);
    chk("sout_wait_clear", 32'(swait), 0);
    pulp = 32'h0;
    tick(1);
    chk("sout_flushed_drop", gpio, 32'hE000_0165);
    sack = 1'b1;
    tick(1);
    sack = 1'b0;
    chk("sout_spurious_gpio", gpio, 32'hE000_0165);
    chk("sout_spurious_wait", 32'(swait), 0);
    // trace flush handshake
    pulp = 32'h10;
    tick(1);
    chk("trace_wait", 32'(twait), 1);
    tack = 1'b1;
    tick(1);
    tack = 1'b0;
    chk("trace_flushed_gpio", gpio, 32'hE000_0175);
    chk("trace_wait_clear", 32'(twait), 0);
    pulp = 32'h0;
    tick(1);
    chk("trace_flushed_drop", gpio, 32'hE000_0165);
    // EOC with RET=2
    pulp = 32'h5;
    tick(1);
    pulp = 32'h0;
    chk("eoc_state", 32'(state), 5);
    chk("eoc_done", 32'(done), 1);
    chk("eoc_ret", 32'(ret), 2);
    chk("eoc_gpio", gpio, 32'hE000_0164);
    tick(1);
    chk("after_done_state", 32'(state), 0);
    chk("after_done_flags", {busy, done}, 0);
    chk("after_done_gpio", gpio, 32'hE000_0164);
    // timeout after exactly 5 RUN cycles, config word 0x80
    cfg(1'b0, 1'b0, 1'b0, 3'b010);
    tmo = 5;
    launch;
    tick(28);
    chk("to_run_gpio", gpio, 32'hC000_0081);
    tick(4);
    chk("to_5th_state", 32'(state), 4);
    chk("to_5th_tout", 32'(tout), 0);
    tick(1);
    chk("to_state", 32'(state), 0);
    chk("to_pulse", 32'(tout), 1);
    chk("to_gpio", gpio, 32'h0000_0080);
    chk("to_done", 32'(done), 0);
    tick(1);
    chk("to_pulse_end", 32'(tout), 0);
    // EOC on the last allowed cycle wins over timeout
    launch;
    tick(32);
    chk("to_eoc_pre_state", 32'(state), 4);
    pulp = 32'h1;
    tick(1);
    pulp = 32'h0;
    chk("to_eoc_done", 32'(done), 1);
    chk("to_eoc_tout", 32'(tout), 0);
    chk("to_eoc_ret", 32'(ret), 0);
    tmo = 0;
    tick(1);
    // abort in CLKON with start held
    cfg(1'b1, 1'b1, 1'b1, 3'b101);
    launch;
    tick(16);
    chk("ab1_pre_state", 32'(state), 2);
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    chk("ab1_state", 32'(state), 0);
    chk("ab1_gpio", gpio, 32'h2000_0164);
    chk("ab1_flags", {busy, done, tout}, 0);
    tick(1);
    chk("ab1_stay_idle", 32'(state), 0);
    // abort in RUN with stdout flushed bit set
    launch;
    tick(28);
    pulp = 32'h8;
    tick(1);
    sack = 1'b1;
    tick(1);
    sack = 1'b0;
    chk("ab2_pre_gpio", gpio, 32'hE000_016D);
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0; pulp = 32'h0;
    chk("ab2_state", 32'(state), 0);
    chk("ab2_gpio", gpio, 32'h2000_0164);
    chk("ab2_flags", {busy, done, tout, swait}, 0);
    tick(1);
    chk("ab2_stay_idle", 32'(state), 0);
    chk("ab2_no_done", 32'(done), 0);
    // synchronous reset mid-RUN
    launch;
    tick(30);
    chk("rst2_pre_state", 32'(state), 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_gpio", gpio, 32'h0000_01C0);
    chk("rst2_state", 32'(state), 0);
    chk("rst2_busy", 32'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
